// File: rtl/demux_1x2_stream_if.sv
// Bus bundle for the 1-to-2 stream demultiplexer.
// Carries the producer side (i_data, s, i_valid, i_ready), the two consumer
// channels (outN_data, outN_valid, outN_ready) and the per-channel counters.
// master : producer/consumer environment driving the block
// slave  : the demultiplexer itself
interface demux_1x2_stream_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic [WIDTH-1:0] i_data;
    logic             s;
    logic             i_valid;
    logic             i_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out2_data;
    logic             out2_valid;
    logic             out2_ready;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    modport master (
        output i_data, s, i_valid, out1_ready, out2_ready,
        input  i_ready, out1_data, out1_valid, out2_data, out2_valid, cnt1, cnt2
    );

    modport slave (
        input  i_data, s, i_valid, out1_ready, out2_ready,
        output i_ready, out1_data, out1_valid, out2_data, out2_valid, cnt1, cnt2
    );
endinterface

// File: rtl/demux_1x2_stream.sv
// Registered, flow-controlled 1-to-2 stream demultiplexer.
// Each accepted word goes to the 2-entry FWFT FIFO picked by s; each channel
// keeps a saturating count of words accepted for it.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of demux_1x2_stream_if (input stream, two output
//          streams, cnt1/cnt2). i_ready is the only combinational output.
module demux_1x2_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    demux_1x2_stream_if.slave      bus
);

    localparam int unsigned NCH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             occ      [NCH];
    occ_t             occ_nxt  [NCH];
    logic [WIDTH-1:0] head     [NCH];
    logic [WIDTH-1:0] head_nxt [NCH];
    logic [WIDTH-1:0] tail     [NCH];
    logic [WIDTH-1:0] tail_nxt [NCH];
    logic [CNT_W-1:0] cnt      [NCH];
    logic [CNT_W-1:0] cnt_nxt  [NCH];
    logic             valid    [NCH];
    logic             push     [NCH];
    logic             pop      [NCH];
    logic             oready   [NCH];
    logic             accept;

    assign oready[0] = bus.out1_ready;
    assign oready[1] = bus.out2_ready;

    // No full-bypass: a FULL channel refuses words even when it pops this cycle.
    assign bus.i_ready = ~rst & (bus.s ? (occ[1] != FULL) : (occ[0] != FULL));
    assign accept      = bus.i_valid & bus.i_ready;

    // Per-channel occupancy / storage / counter next-state.
    always_comb begin
        for (int c = 0; c < int'(NCH); c++) begin
            push[c]     = accept & (bus.s == 1'(c));
            pop[c]      = valid[c] & oready[c];
            occ_nxt[c]  = occ[c];
            head_nxt[c] = head[c];
            tail_nxt[c] = tail[c];
            cnt_nxt[c]  = cnt[c];

            case (occ[c])
                EMPTY: begin
                    if (push[c]) begin
                        head_nxt[c] = bus.i_data;
                        occ_nxt[c]  = ONE;
                    end
                end
                ONE: begin
                    if (push[c] && pop[c]) begin
                        head_nxt[c] = bus.i_data;
                    end else if (push[c]) begin
                        tail_nxt[c] = bus.i_data;
                        occ_nxt[c]  = FULL;
                    end else if (pop[c]) begin
                        // Empty head reads as zero.
                        head_nxt[c] = '0;
                        occ_nxt[c]  = EMPTY;
                    end
                end
                FULL: begin
                    if (pop[c]) begin
                        head_nxt[c] = tail[c];
                        tail_nxt[c] = '0;
                        occ_nxt[c]  = ONE;
                    end
                end
                default: begin
                    occ_nxt[c]  = EMPTY;
                    head_nxt[c] = '0;
                    tail_nxt[c] = '0;
                end
            endcase

            if (push[c] && (cnt[c] != {CNT_W{1'b1}})) begin
                cnt_nxt[c] = cnt[c] + CNT_W'(1);
            end
        end
    end

    // State registers; reset discards buffered words and clears counters.
    always_ff @(posedge clk) begin
        for (int c = 0; c < int'(NCH); c++) begin
            if (rst) begin
                occ[c]   <= EMPTY;
                head[c]  <= '0;
                tail[c]  <= '0;
                cnt[c]   <= '0;
                valid[c] <= 1'b0;
            end else begin
                occ[c]   <= occ_nxt[c];
                head[c]  <= head_nxt[c];
                tail[c]  <= tail_nxt[c];
                cnt[c]   <= cnt_nxt[c];
                valid[c] <= (occ_nxt[c] != EMPTY);
            end
        end
    end

    assign bus.out1_data  = head[0];
    assign bus.out1_valid = valid[0];
    assign bus.out2_data  = head[1];
    assign bus.out2_valid = valid[1];
    assign bus.cnt1       = cnt[0];
    assign bus.cnt2       = cnt[1];

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Directed testbench for demux_1x2_stream (CNT_W=4 so saturation is reachable).
module tb_demux_1x2_stream;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic clk;
    logic rst;

    demux_1x2_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    demux_1x2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic       s;
        logic       v;
        logic       r1;
        logic       r2;
        logic       rdy;   // i_ready before the edge
        logic       v1;    // outputs after the edge
        logic [7:0] d1;
        logic       v2;
        logic [7:0] d2;
        logic [3:0] c1;
        logic [3:0] c2;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [7:0] d, input logic s, input logic v,
                       input logic r1, input logic r2, input logic rdy,
                       input logic v1, input logic [7:0] d1, input logic v2,
                       input logic [7:0] d2, input logic [3:0] c1, input logic [3:0] c2);
        vec_t t;
        t = '{r, d, s, v, r1, r2, rdy, v1, d1, v2, d2, c1, c2};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] d, input logic s, input logic v,
                         input logic r1, input logic r2);
        rst            = r;
        bus.i_data     = d;
        bus.s          = s;
        bus.i_valid    = v;
        bus.out1_ready = r1;
        bus.out2_ready = r2;
    endtask

    task automatic chk_out(input string tag, input logic v1, input logic [7:0] d1,
                           input logic v2, input logic [7:0] d2,
                           input logic [3:0] c1, input logic [3:0] c2);
        chk({tag, ".out1_valid"}, 32'(bus.out1_valid), 32'(v1));
        chk({tag, ".out1_data"},  32'(bus.out1_data),  32'(d1));
        chk({tag, ".out2_valid"}, 32'(bus.out2_valid), 32'(v2));
        chk({tag, ".out2_data"},  32'(bus.out2_data),  32'(d2));
        chk({tag, ".cnt1"},       32'(bus.cnt1),       32'(c1));
        chk({tag, ".cnt2"},       32'(bus.cnt2),       32'(c2));
    endtask

    initial begin
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        //   rst   d      s     v     r1    r2    rdy   v1    d1     v2    d2     c1     c2
        // reset for two cycles, then idle
        add(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 4'd0);
        add(1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 4'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 4'd0);
        // A1 -> ch1, B2 -> ch2, both consumers ready
        add(1'b0, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 8'h00, 4'd1, 4'd0);
        add(1'b0, 8'hB2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hB2, 4'd1, 4'd1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 4'd1, 4'd1);
        // ch1 stalled: 01, 02 accepted, 03 refused (also refused on the pop cycle)
        add(1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 4'd2, 4'd1);
        add(1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 4'd3, 4'd1);
        add(1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 4'd3, 4'd1);
        add(1'b0, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 4'd3, 4'd1);
        add(1'b0, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 8'h00, 4'd4, 4'd1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 4'd4, 4'd1);
        // fill ch1, then 55 still flows to ch2
        add(1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 4'd5, 4'd1);
        add(1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 4'd6, 4'd1);
        add(1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 8'h55, 4'd6, 4'd2);
        // ch2 in ONE: push 77 and pop together
        add(1'b0, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'h77, 4'd6, 4'd3);
        // drain: ch2 empties, ch1 FULL -> ONE with 12 at head, then empty
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 8'h00, 4'd6, 4'd3);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 4'd6, 4'd3);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].d, vecs[i].s, vecs[i].v, vecs[i].r1, vecs[i].r2);
            #1;
            chk($sformatf("v%0d.i_ready", i), 32'(bus.i_ready), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            chk_out($sformatf("v%0d", i), vecs[i].v1, vecs[i].d1, vecs[i].v2, vecs[i].d2,
                    vecs[i].c1, vecs[i].c2);
        end

        // Saturation: reset, then 17 words to ch1 with consumer always ready.
        @(negedge clk);
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk_out("sat.rst", 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 4'd0);
        for (int n = 1; n <= 17; n++) begin
            logic [7:0] w;
            w = 8'(8'h20 + n);
            @(negedge clk);
            drive(1'b0, w, 1'b0, 1'b1, 1'b1, 1'b1);
            #1;
            chk($sformatf("sat%0d.i_ready", n), 32'(bus.i_ready), 32'd1);
            @(posedge clk);
            #1;
            chk_out($sformatf("sat%0d", n), 1'b1, w, 1'b0, 8'h00,
                    (n >= 15) ? 4'd15 : 4'(n), 4'd0);
        end

        // Buffer two words in ch1 and one in ch2, then a single reset clock.
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);   // drain remaining head
        @(negedge clk);
        drive(1'b0, 8'hC1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'hC2, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'hD1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_out("pre_rst", 1'b1, 8'hC1, 1'b1, 8'hD1, 4'd15, 4'd1);
        @(negedge clk);
        drive(1'b1, 8'hE1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("mid_rst.i_ready", 32'(bus.i_ready), 32'd0);
        @(posedge clk);
        #1;
        chk_out("mid_rst", 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 4'd0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk_out("post_rst", 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
